// File: rtl/shift_pkg.sv
`default_nettype none
// ============================================================================
// Module  : shift_pkg
// Brief   : Shared widths and op-code encodings for the shift arbiter slice.
// Revision: 1.0 - initial release
// ============================================================================
package shift_pkg;

  localparam int DATA_W = 8;
  localparam int AMT_W  = 3;

  localparam logic [2:0] OP_LSL = 3'b000;
  localparam logic [2:0] OP_LSR = 3'b001;
  localparam logic [2:0] OP_ASR = 3'b010;
  localparam logic [2:0] OP_ROR = 3'b011;
  localparam logic [2:0] OP_ROL = 3'b100;

endpackage
`default_nettype wire

// File: rtl/shift_core.sv
`default_nettype none
// ============================================================================
// Module  : shift_core
// Brief   : Combinational 8-bit barrel shifter (LSL/LSR/ASR/ROR/ROL/pass).
// Revision: 1.0 - initial release
// ============================================================================
module shift_core
  import shift_pkg::*;
(
  input  logic [DATA_W-1:0] data,
  input  logic [AMT_W-1:0]  amt,
  input  logic [2:0]        op,
  output logic [DATA_W-1:0] result
);

  logic [2*DATA_W-1:0] w_dd;
  logic [2*DATA_W-1:0] w_ror;
  logic [2*DATA_W-1:0] w_rol;
  logic [DATA_W-1:0]   w_asr;

  // Rotates fall out of shifting the operand concatenated with itself.
  assign w_dd  = {data, data};
  assign w_ror = w_dd >> amt;
  assign w_rol = w_dd << amt;
  assign w_asr = $unsigned($signed(data) >>> amt);

  always_comb begin
    result = data;
    case (op)
      OP_LSL:  result = data << amt;
      OP_LSR:  result = data >> amt;
      OP_ASR:  result = w_asr;
      OP_ROR:  result = w_ror[DATA_W-1:0];
      OP_ROL:  result = w_rol[2*DATA_W-1:DATA_W];
      default: result = data;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/shift_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : shift_arbiter
// Brief   : Round-robin sharing of one barrel shifter among NREQ requesters,
//           with a registered, source-tagged valid/ready output.
// Revision: 1.0 - initial release
// ============================================================================
module shift_arbiter
  import shift_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int IDW  = $clog2(NREQ),
  parameter int CNTW = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NREQ-1:0]        req_valid,
  output logic [NREQ-1:0]        req_ready,
  input  logic [DATA_W*NREQ-1:0] req_data,
  input  logic [AMT_W*NREQ-1:0]  req_amt,
  input  logic [3*NREQ-1:0]      req_type,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [DATA_W-1:0]      out_data,
  output logic [IDW-1:0]         out_src,
  output logic [CNTW-1:0]        done_cnt
);

  logic [IDW-1:0]    r_ptr;
  logic              r_out_valid;
  logic [DATA_W-1:0] r_out_data;
  logic [IDW-1:0]    r_out_src;
  logic [CNTW-1:0]   r_done_cnt;

  logic [IDW-1:0]    w_gnt_idx;
  logic              w_gnt_any;
  logic              w_accept;
  logic              w_xfer;
  logic [IDW-1:0]    w_ptr_nxt;
  logic [DATA_W-1:0] w_op_data;
  logic [AMT_W-1:0]  w_op_amt;
  logic [2:0]        w_op_type;
  logic [DATA_W-1:0] w_result;

  // First valid requester at or after the pointer, wrapping at NREQ.
  always_comb begin
    w_gnt_any = 1'b0;
    w_gnt_idx = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (!w_gnt_any && req_valid[(int'(r_ptr) + k) % NREQ]) begin
        w_gnt_any = 1'b1;
        w_gnt_idx = IDW'((int'(r_ptr) + k) % NREQ);
      end
    end
  end

  // Gating with rst_n keeps every ready low while reset is held.
  assign w_accept  = rst_n && (!r_out_valid || out_ready);
  assign w_xfer    = w_accept && w_gnt_any;
  assign w_ptr_nxt = (int'(w_gnt_idx) == NREQ - 1) ? '0 : w_gnt_idx + 1'b1;

  always_comb begin
    req_ready = '0;
    if (w_xfer) req_ready[w_gnt_idx] = 1'b1;
  end

  assign w_op_data = req_data[DATA_W*w_gnt_idx +: DATA_W];
  assign w_op_amt  = req_amt[AMT_W*w_gnt_idx +: AMT_W];
  assign w_op_type = req_type[3*w_gnt_idx +: 3];

  shift_core u_core (
    .data   (w_op_data),
    .amt    (w_op_amt),
    .op     (w_op_type),
    .result (w_result)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr       <= '0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_src   <= '0;
      r_done_cnt  <= '0;
    end else begin
      if (w_xfer) begin
        r_out_valid <= 1'b1;
        r_out_data  <= w_result;
        r_out_src   <= w_gnt_idx;
        r_ptr       <= w_ptr_nxt;
      end else if (out_ready) begin
        r_out_valid <= 1'b0;
      end
      if (r_out_valid && out_ready) r_done_cnt <= r_done_cnt + 1'b1;
    end
  end

  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_src   = r_out_src;
  assign done_cnt  = r_done_cnt;

endmodule
`default_nettype wire
